// File: rtl/uart_rx_controller.sv
// uart_rx_controller: sequences a uart_receiver datapath and buffers its good bytes.
// Synchronises the serial line, times mid-bit sample ticks for each frame,
// judges the stop bit and queues good bytes in a first-word-fall-through FIFO.
// Optional build macro UART_RX_BREAK_DETECT_EN adds break detection: an all-zero
// frame with a framing error pulses break_detect. After a break, new frames are
// held off until the line has been high for one bit time.
module uart_rx_controller #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx,
    input  logic                          rx_enable,
    output logic                          rx_line,
    output logic                          baud_rate_signal,
    input  logic [7:0]                    rcv_data,
    input  logic                          rcv_valid,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_error,
    output logic                          overrun,
    output logic                          busy,
    output logic                          break_detect
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    // The timer counts down to zero and the tick is registered one clock later.
    // Loading half-bit minus two therefore lands the first tick exactly half a
    // bit after the edge-detect cycle.
    localparam logic [TW-1:0] FIRST_LOAD = TW'(CLKS_PER_BIT / 2 - 2);
    localparam logic [TW-1:0] BIT_LOAD   = TW'(CLKS_PER_BIT - 1);

    typedef enum logic {HUNT, FRAME} state_t;

    state_t          state;
    logic            sync_meta;
    logic            line_d;
    logic [TW-1:0]   timer;
    logic [3:0]      tick_cnt;
    logic            rearm_hold;
    logic            start_edge;
    logic            stop_tick;
    logic            push;
    logic            pop;
    logic            full;
    logic            accept;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      mem [FIFO_DEPTH];

    assign start_edge = state == HUNT && line_d && !rx_line && rx_enable && !rearm_hold;
    assign stop_tick  = state == FRAME && baud_rate_signal && tick_cnt == 4'd9;
    assign push       = stop_tick && rcv_valid;
    assign pop        = out_valid && out_ready;
    assign full       = fifo_count == CW'(FIFO_DEPTH);
    assign accept     = push && (!full || pop);
    assign busy       = state == FRAME;
    assign out_valid  = fifo_count != '0;
    assign out_data   = out_valid ? mem[rd_ptr] : 8'h00;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b1;
            rx_line   <= 1'b1;
            line_d    <= 1'b1;
        end else begin
            sync_meta <= uart_rx;
            rx_line   <= sync_meta;
            line_d    <= rx_line;
        end
    end

    // Frame sequencer: hunts for a start edge, then issues ten mid-bit ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= HUNT;
            timer            <= '0;
            tick_cnt         <= '0;
            baud_rate_signal <= 1'b0;
            framing_error    <= 1'b0;
        end else begin
            framing_error <= stop_tick && !rcv_valid;
            if (state == HUNT) begin
                baud_rate_signal <= 1'b0;
                if (start_edge) begin
                    state    <= FRAME;
                    timer    <= FIRST_LOAD;
                    tick_cnt <= '0;
                end
            end else begin
                baud_rate_signal <= timer == '0;
                timer            <= timer == '0 ? BIT_LOAD : timer - 1'b1;
                if (baud_rate_signal) begin
                    tick_cnt <= tick_cnt + 4'd1;
                    // A high line at the start-bit sample is a glitch; drop it silently.
                    if ((tick_cnt == 4'd0 && rx_line) || tick_cnt == 4'd9) begin
                        state            <= HUNT;
                        baud_rate_signal <= 1'b0;
                    end
                end
            end
        end
    end

    // FIFO pointers, occupancy and overrun flag; a full FIFO still accepts a push alongside a pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            overrun    <= push && full && !pop;
            wr_ptr     <= accept ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
            fifo_count <= fifo_count + CW'(accept) - CW'(pop);
        end
    end

    // FIFO storage; contents need no reset because occupancy gates the output.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= rcv_data;
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic [TW-1:0] high_cnt;

    // Break flag and re-arm hold-off: waits for one full bit time of idle-high line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            break_detect <= 1'b0;
            rearm_hold   <= 1'b0;
            high_cnt     <= '0;
        end else begin
            break_detect <= stop_tick && !rcv_valid && rcv_data == 8'h00;
            if (stop_tick && !rcv_valid && rcv_data == 8'h00) begin
                rearm_hold <= 1'b1;
                high_cnt   <= '0;
            end else if (rearm_hold) begin
                high_cnt   <= !rx_line || high_cnt == BIT_LOAD ? '0 : high_cnt + 1'b1;
                rearm_hold <= !(rx_line && high_cnt == BIT_LOAD);
            end
        end
    end
`else
    assign break_detect = 1'b0;
    assign rearm_hold   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// tb_uart_rx_controller: directed bench for uart_rx_controller with a behavioural receiver.
module tb_uart_rx_controller;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rx_enable = 1'b1;
    logic       out_ready = 1'b0;
    logic       rx_line;
    logic       baud_rate_signal;
    logic [7:0] rcv_data;
    logic       rcv_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] fifo_count;
    logic       framing_error;
    logic       overrun;
    logic       busy;
    logic       break_detect;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int tick_n = 0;
    int fe_n = 0;
    int ov_n = 0;
    int bd_n = 0;
    int fe_cyc = -1;
    int bd_cyc = -2;
    int frame_t0 = 0;
    int tq[$];

    uart_rx_controller #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .rx_enable(rx_enable),
        .rx_line(rx_line), .baud_rate_signal(baud_rate_signal),
        .rcv_data(rcv_data), .rcv_valid(rcv_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_count(fifo_count), .framing_error(framing_error), .overrun(overrun),
        .busy(busy), .break_detect(break_detect)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural uart_receiver: LSB-first shift on data ticks, valid at a high stop bit.
    logic [3:0] m_cnt;
    logic [7:0] m_sh;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt <= 4'd0;
            m_sh  <= 8'h00;
        end else if (baud_rate_signal) begin
            if (m_cnt == 4'd0)
                m_cnt <= rx_line ? 4'd0 : 4'd1;
            else if (m_cnt == 4'd9)
                m_cnt <= 4'd0;
            else begin
                m_cnt <= m_cnt + 4'd1;
                m_sh  <= {rx_line, m_sh[7:1]};
            end
        end
    end
    assign rcv_data  = m_sh;
    assign rcv_valid = baud_rate_signal && m_cnt == 4'd9 && rx_line;

    // Pulse monitors sampled on the falling edge.
    always @(negedge clk) begin
        if (baud_rate_signal) begin
            tick_n <= tick_n + 1;
            tq.push_back(cyc);
        end
        if (framing_error) begin
            fe_n   <= fe_n + 1;
            fe_cyc <= cyc;
        end
        if (overrun) ov_n <= ov_n + 1;
        if (break_detect) begin
            bd_n   <= bd_n + 1;
            bd_cyc <= cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        @(posedge clk);
        #1;
        frame_t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
        repeat (24) @(posedge clk);
        #1;
    endtask

    task automatic pop_byte(input logic [7:0] exp);
        check("pop_valid", 32'(out_valid), 32'd1);
        check("pop_data", 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int b;
        int n0;
        int n1;
        int fe0;
        int bd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_line", 32'(rx_line), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_baud", 32'(baud_rate_signal), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_fe", 32'(framing_error), 32'd0);
        check("rst_ov", 32'(overrun), 32'd0);
        check("rst_bd", 32'(break_detect), 32'd0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 0xA5: edge detect is 2 sync clocks after the line drop, first tick 8 after that.
        b  = tq.size();
        n0 = tick_n;
        send(8'hA5, 1'b1);
        check("a5_ticks", 32'(tick_n - n0), 32'd10);
        check("a5_first", 32'(tq.size() > b ? tq[b] - frame_t0 : -1), 32'd10);
        check("a5_space", 32'(tq.size() > b + 1 ? tq[b+1] - tq[b] : -1), 32'd16);
        check("a5_last", 32'(tq.size() > b + 9 ? tq[b+9] - tq[b] : -1), 32'd144);
        check("a5_valid", 32'(out_valid), 32'd1);
        check("a5_data", 32'(out_data), 32'hA5);
        check("a5_count", 32'(fifo_count), 32'd1);
        check("a5_fe", 32'(fe_n), 32'd0);
        check("a5_ov", 32'(ov_n), 32'd0);
        pop_byte(8'hA5);
        check("a5_drained", 32'(fifo_count), 32'd0);

        // Start-bit glitch of 4 clocks: one tick at t0+10, back in HUNT at t0+11.
        n0 = tick_n;
        @(posedge clk);
        #1;
        uart_rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        check("glitch_busy", 32'(busy), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("glitch_ticks", 32'(tick_n - n0), 32'd1);
        check("glitch_count", 32'(fifo_count), 32'd0);
        check("glitch_fe", 32'(fe_n), 32'd0);
        check("glitch_ov", 32'(ov_n), 32'd0);

        // Bad stop bit.
        send(8'h3C, 1'b0);
        check("fe_pulses", 32'(fe_n), 32'd1);
        check("fe_count", 32'(fifo_count), 32'd0);
        check("fe_valid", 32'(out_valid), 32'd0);
        check("fe_break", 32'(bd_n), 32'd0);

        // Overrun on the fifth byte.
        for (int v = 1; v <= 5; v++) send(8'(v), 1'b1);
        check("ovr_count", 32'(fifo_count), 32'd4);
        check("ovr_pulses", 32'(ov_n), 32'd1);
        for (int v = 1; v <= 4; v++) pop_byte(8'(v));
        check("ovr_empty", 32'(out_valid), 32'd0);

        // Full FIFO with a pop exactly in the stop-tick cycle (t0+154).
        for (int v = 8'h11; v <= 8'h14; v++) send(8'(v), 1'b1);
        check("full_count", 32'(fifo_count), 32'd4);
        fork
            send(8'h15, 1'b1);
            begin
                @(posedge clk);
                #1;
                repeat (154) @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
            end
        join
        check("full_pop_ov", 32'(ov_n), 32'd1);
        check("full_pop_count", 32'(fifo_count), 32'd4);
        for (int v = 8'h12; v <= 8'h15; v++) pop_byte(8'(v));
        check("full_pop_empty", 32'(out_valid), 32'd0);

        // rx_enable low blocks starts; dropping it mid-frame lets the frame finish.
        rx_enable = 1'b0;
        n0 = tick_n;
        send(8'h99, 1'b1);
        check("dis_ticks", 32'(tick_n - n0), 32'd0);
        check("dis_count", 32'(fifo_count), 32'd0);
        rx_enable = 1'b1;
        fork
            send(8'h66, 1'b1);
            begin
                @(posedge clk);
                #1;
                repeat (40) @(posedge clk);
                #1;
                rx_enable = 1'b0;
            end
        join
        check("mid_dis_count", 32'(fifo_count), 32'd1);
        check("mid_dis_data", 32'(out_data), 32'h66);
        rx_enable = 1'b1;
        pop_byte(8'h66);

        // Reset two clocks after tick 4 of a frame.
        send(8'h42, 1'b1);
        check("pre_rst_count", 32'(fifo_count), 32'd1);
        n0 = tick_n;
        n1 = 0;
        fork
            send(8'h77, 1'b1);
            begin
                @(posedge clk);
                #1;
                repeat (60) @(posedge clk);
                #1;
                reset = 1'b1;
                n1 = tick_n;
            end
        join
        check("rst_mid_ticks", 32'(n1 - n0), 32'd4);
        check("rst_mid_stop", 32'(tick_n - n1), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_count", 32'(fifo_count), 32'd0);
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        fe0 = fe_n;
        send(8'h5A, 1'b1);
        check("after_rst_valid", 32'(out_valid), 32'd1);
        check("after_rst_data", 32'(out_data), 32'h5A);
        check("after_rst_count", 32'(fifo_count), 32'd1);
        check("after_rst_fe", 32'(fe_n - fe0), 32'd0);
        pop_byte(8'h5A);

        // All-zero frame with a low stop bit.
        fe0 = fe_n;
        bd0 = bd_n;
        send(8'h00, 1'b0);
        check("brk_fe", 32'(fe_n - fe0), 32'd1);
        check("brk_count", 32'(fifo_count), 32'd0);
`ifdef UART_RX_BREAK_DETECT_EN
        check("brk_pulse", 32'(bd_n - bd0), 32'd1);
        check("brk_same_cycle", 32'(bd_cyc), 32'(fe_cyc));
`else
        check("brk_pulse", 32'(bd_n - bd0), 32'd0);
`endif
        send(8'h81, 1'b1);
        check("brk_rearm_data", 32'(out_data), 32'h81);
        check("brk_rearm_count", 32'(fifo_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
